id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Parametrised ID-stage pipeline register and operand resolver for the 5-stage MIPS core; sits between IF and the decoder/EX.
//  Resolves rs/rt operands from NUM_FWD forwarding sources and the regfile, raises stallreq on load-use hazards, and latches
//  the instruction and operands during stalls so values forwarded from moving stages are never lost.
// PARAMETERS
//  DATA_W   32  operand/forward data width
//  PC_W     32  pc width
//  REG_AW   5   register address width (x0 hard-wired zero)
//  NUM_FWD  3   forwarding sources; index 0 = youngest (EX), ascending = older (MEM, WB)
//  CNT_W    16  stall-cycle counter width
// PORTS
//  clk           in   1                 clock, all state on rising edge
//  rst           in   1                 asynchronous, active-low reset (asserted when 0)
//  stall_id      in   1                 stall[1] of StallBus: ID must not advance
//  stall_ex      in   1                 stall[2] of StallBus: EX must not advance
//  if_valid      in   1                 IF slot holds a real instruction (ce)
//  if_pc         in   PC_W              pc of IF slot
//  inst_sram_rdata in 32                instruction word, valid the cycle after if_pc is captured
//  rf_rdata1     in   DATA_W            regfile read data for rf_raddr1 (combinational regfile)
//  rf_rdata2     in   DATA_W            regfile read data for rf_raddr2
//  fwd_we        in   NUM_FWD           source i writes a register
//  fwd_waddr     in   NUM_FWD*REG_AW    dest of source i, slice i = [i*REG_AW +: REG_AW]
//  fwd_wdata     in   NUM_FWD*DATA_W    result of source i
//  fwd_pending   in   NUM_FWD           source i's data not yet available (load in flight)
//  src1_used     in   1                 decoder: instruction reads rs
//  src2_used     in   1                 decoder: instruction reads rt
//  rf_raddr1     out  REG_AW            = id_inst[25:21]
//  rf_raddr2     out  REG_AW            = id_inst[20:16]
//  id_valid      out  1                 ID slot holds a real instruction
//  id_pc         out  PC_W              pc of ID slot
//  id_inst       out  32                instruction of ID slot (0 when !id_valid)
//  src1_data     out  DATA_W            resolved rs operand
//  src2_data     out  DATA_W            resolved rt operand
//  stallreq      out  1                 load-use hazard, request pipeline stall
//  stall_cnt     out  CNT_W             saturating count of cycles with stallreq=1
// BEHAVIOUR
//  Reset (rst=0, async): id_valid=0, id_pc=0, inst latch/flags cleared, stall_cnt=0; outputs 0 while held.
//  Slot register each edge: stall_id&!stall_ex -> bubble (id_valid=0,id_pc=0); !stall_id -> load if_valid/if_pc; else hold.
//  Instruction: id_inst = !id_valid ? 0 : inst_held ? inst_q : inst_sram_rdata. First edge with id_valid&stall_id:
//   inst_q<=inst_sram_rdata, inst_held<=1. inst_held cleared on any edge where slot loads or bubbles.
//  Live resolve per operand (addr a): a==0 -> 0, ready. Else lowest i with fwd_we[i]&waddr[i]==a selected:
//   ready=!fwd_pending[i], data=wdata[i]. No match -> rf data, ready. Pending younger match blocks even if older ready match.
//  Operand FSM per operand, states OPEN/CAPTURED: OPEN->CAPTURED on edge with id_valid&stall_id&ready (latch live data).
//   CAPTURED->OPEN on edge where slot loads or bubbles. Output = CAPTURED ? latched : live data.
//   CAPTURED operand counts as ready; src*_data irrelevant when !id_valid but must be 0.
//  stallreq = id_valid & ((src1_used&!rdy1)|(src2_used&!rdy2)); combinational, same cycle as hazard.
//  stall_cnt increments each edge with stallreq=1, saturates at all-ones, no wrap.
//  Simultaneous: bubble wins over capture; reset mid-stall discards latched operands and inst.
//  Same register in both rs and rt resolved independently, identical result.
// TESTING
//  1 Reset mid-stall: CAPTURED state, rst=0 -> id_valid=0, src*_data=0, stall_cnt=0 immediately (async).
//  2 Priority: EX and MEM both write r5 (0xAAAA/0xBBBB), addu reads r5 -> src1_data=0xAAAA, stallreq=0.
//  3 Load-use: lw r3 in EX (pending=1), next addu r4,r3,r3 -> stallreq=1 one cycle; then MEM supplies 0x1234 -> src1=src2=0x1234.
//  4 Capture: stall_id=1 three cycles, WB forwards r7=0x55 in cycle 1 then leaves -> src2_data stays 0x55 all cycles.
//  5 Bubble: stall_id=1,stall_ex=0 -> next edge id_valid=0,id_pc=0,id_inst=0; x0 read with fwd_we to r0 -> operand 0.
//  6 Saturation: CNT_W=4, hold stallreq 20 cycles -> stall_cnt=15, no wrap.

Source files
------------

// File: rtl/id_operand_stage.sv
// -----------------------------------------------------------------------------
// id_operand_stage
//
// ID-stage pipeline register and operand resolver for the 5-stage MIPS core.
// It sits between IF and the decoder/EX stages and does four things:
//   * holds the ID slot (valid + pc), with hold, load and bubble behaviour
//     driven by the stall bus;
//   * keeps the instruction word stable while ID is stalled, because the
//     instruction SRAM output moves on once IF stops presenting the same pc;
//   * resolves the rs/rt operands from NUM_FWD forwarding sources (index 0 is
//     the youngest, EX) or the combinational register file;
//   * raises stallreq on a load-use hazard and counts stalled cycles.
//
// During a stall an operand that becomes ready is latched once. The forwarding
// source that supplied it keeps moving down the pipe and will not be there
// on later cycles.
//
// Ports
//   clk, rst          clock (rising edge) / asynchronous active-low reset
//   stall_id          ID must not advance
//   stall_ex          EX must not advance (stall_id & !stall_ex bubbles ID)
//   if_valid, if_pc   contents of the IF slot
//   inst_sram_rdata   instruction word for the pc now held in ID
//   rf_raddr1/2       regfile read addresses (rs / rt of id_inst)
//   rf_rdata1/2       regfile read data, same cycle
//   fwd_we/waddr/wdata/pending   forwarding sources, slice i = source i
//   src1_used/src2_used          decoder says rs / rt is actually read
//   id_valid, id_pc, id_inst     ID slot contents (id_inst is 0 when empty)
//   src1_data, src2_data         resolved operands (0 when slot empty)
//   stallreq          load-use hazard, combinational
//   stall_cnt         saturating count of cycles with stallreq high
// -----------------------------------------------------------------------------
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_id,
  input  logic                        stall_ex,
  input  logic                        if_valid,
  input  logic [PC_W-1:0]             if_pc,
  input  logic [31:0]                 inst_sram_rdata,
  input  logic [DATA_W-1:0]           rf_rdata1,
  input  logic [DATA_W-1:0]           rf_rdata2,
  input  logic [NUM_FWD-1:0]          fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
  input  logic [NUM_FWD-1:0]          fwd_pending,
  input  logic                        src1_used,
  input  logic                        src2_used,
  output logic [REG_AW-1:0]           rf_raddr1,
  output logic [REG_AW-1:0]           rf_raddr2,
  output logic                        id_valid,
  output logic [PC_W-1:0]             id_pc,
  output logic [31:0]                 id_inst,
  output logic [DATA_W-1:0]           src1_data,
  output logic [DATA_W-1:0]           src2_data,
  output logic                        stallreq,
  output logic [CNT_W-1:0]            stall_cnt
);

  // Per-operand capture state: OPEN follows the live resolution, CAPTURED
  // replays the value latched during the current stall.
  typedef enum logic {
    OPD_OPEN     = 1'b0,
    OPD_CAPTURED = 1'b1
  } opd_state_e;

  // Resolve one operand address against the forwarding sources and the
  // regfile. Returns {ready, data}. Sources are scanned oldest to youngest
  // so the youngest match is the last one written and wins; a pending
  // youngest match therefore blocks even when an older source is ready.
  function automatic logic [DATA_W:0] resolve_operand(
    input logic [REG_AW-1:0]         addr,
    input logic [DATA_W-1:0]         rf_data,
    input logic [NUM_FWD-1:0]        we,
    input logic [NUM_FWD*REG_AW-1:0] waddr,
    input logic [NUM_FWD*DATA_W-1:0] wdata,
    input logic [NUM_FWD-1:0]        pending
  );
    logic              rdy;
    logic [DATA_W-1:0] data;
    rdy  = 1'b1;
    data = rf_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (we[i] && (waddr[i*REG_AW +: REG_AW] == addr)) begin
        rdy  = ~pending[i];
        data = wdata[i*DATA_W +: DATA_W];
      end else begin
        rdy  = rdy;
        data = data;
      end
    end
    // Register 0 is hard-wired: nothing written to it is ever visible.
    if (addr == {REG_AW{1'b0}}) begin
      rdy  = 1'b1;
      data = {DATA_W{1'b0}};
    end else begin
      rdy  = rdy;
      data = data;
    end
    return {rdy, data};
  endfunction

  // Slot and instruction state
  logic              id_valid_r;
  logic [PC_W-1:0]   id_pc_r;
  logic [31:0]       inst_q_r;
  logic              inst_held_r;
  logic [31:0]       id_inst_s;

  // Slot control decoded from the stall bus
  logic              slot_load_s;
  logic              slot_bubble_s;
  logic              slot_release_s;

  // Operand resolution and capture
  logic [DATA_W:0]   res1_s;
  logic [DATA_W:0]   res2_s;
  logic [DATA_W-1:0] live_data_s       [2];
  logic              live_rdy_s        [2];
  opd_state_e        opd_state_r       [2];
  opd_state_e        opd_state_nxt_s   [2];
  logic              opd_capture_s     [2];
  logic [DATA_W-1:0] opd_q_r           [2];
  logic [DATA_W-1:0] opd_data_s        [2];
  logic              opd_rdy_s         [2];

  logic              stallreq_s;
  logic [CNT_W-1:0]  stall_cnt_r;

  // Bubble takes priority over hold; any load or bubble ends the current
  // stall episode and releases the instruction and operand latches.
  assign slot_load_s    = ~stall_id;
  assign slot_bubble_s  = stall_id & ~stall_ex;
  assign slot_release_s = slot_load_s | slot_bubble_s;

  // ID slot register: bubble, load from IF, or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_r <= 1'b0;
      id_pc_r    <= {PC_W{1'b0}};
    end else if (slot_bubble_s) begin
      id_valid_r <= 1'b0;
      id_pc_r    <= {PC_W{1'b0}};
    end else if (slot_load_s) begin
      id_valid_r <= if_valid;
      id_pc_r    <= if_pc;
    end else begin
      id_valid_r <= id_valid_r;
      id_pc_r    <= id_pc_r;
    end
  end

  // Instruction latch: grab the SRAM word on the first stalled edge, since
  // the SRAM output is not guaranteed to stay put while ID is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q_r    <= 32'h0000_0000;
      inst_held_r <= 1'b0;
    end else if (slot_release_s) begin
      inst_q_r    <= inst_q_r;
      inst_held_r <= 1'b0;
    end else if (id_valid_r && !inst_held_r) begin
      inst_q_r    <= inst_sram_rdata;
      inst_held_r <= 1'b1;
    end else begin
      inst_q_r    <= inst_q_r;
      inst_held_r <= inst_held_r;
    end
  end

  // Instruction seen by the decoder and by the operand address fields.
  always_comb begin
    id_inst_s = 32'h0000_0000;
    if (!id_valid_r) begin
      id_inst_s = 32'h0000_0000;
    end else if (inst_held_r) begin
      id_inst_s = inst_q_r;
    end else begin
      id_inst_s = inst_sram_rdata;
    end
  end

  assign rf_raddr1 = id_inst_s[21 +: REG_AW];
  assign rf_raddr2 = id_inst_s[16 +: REG_AW];

  assign res1_s = resolve_operand(rf_raddr1, rf_rdata1, fwd_we, fwd_waddr,
                                  fwd_wdata, fwd_pending);
  assign res2_s = resolve_operand(rf_raddr2, rf_rdata2, fwd_we, fwd_waddr,
                                  fwd_wdata, fwd_pending);

  assign live_rdy_s[0]  = res1_s[DATA_W];
  assign live_data_s[0] = res1_s[DATA_W-1:0];
  assign live_rdy_s[1]  = res2_s[DATA_W];
  assign live_data_s[1] = res2_s[DATA_W-1:0];

  // Operand FSM next state: capture a ready operand while stalled, drop the
  // capture when the slot moves. A bubble on the same edge wins over capture.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      opd_state_nxt_s[k] = opd_state_r[k];
      opd_capture_s[k]   = 1'b0;
      case (opd_state_r[k])
        OPD_OPEN: begin
          if (slot_release_s) begin
            opd_state_nxt_s[k] = OPD_OPEN;
          end else if (id_valid_r && live_rdy_s[k]) begin
            opd_state_nxt_s[k] = OPD_CAPTURED;
            opd_capture_s[k]   = 1'b1;
          end else begin
            opd_state_nxt_s[k] = OPD_OPEN;
          end
        end
        OPD_CAPTURED: begin
          if (slot_release_s) begin
            opd_state_nxt_s[k] = OPD_OPEN;
          end else begin
            opd_state_nxt_s[k] = OPD_CAPTURED;
          end
        end
        default: begin
          opd_state_nxt_s[k] = OPD_OPEN;
        end
      endcase
    end
  end

  // Operand FSM state register and captured-value latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        opd_state_r[k] <= OPD_OPEN;
        opd_q_r[k]     <= {DATA_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        opd_state_r[k] <= opd_state_nxt_s[k];
        if (opd_capture_s[k]) begin
          opd_q_r[k] <= live_data_s[k];
        end else begin
          opd_q_r[k] <= opd_q_r[k];
        end
      end
    end
  end

  // Operand outputs: captured value replaces the live one and counts as
  // ready; an empty slot drives zeros.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      opd_data_s[k] = {DATA_W{1'b0}};
      opd_rdy_s[k]  = 1'b0;
      if (opd_state_r[k] == OPD_CAPTURED) begin
        opd_rdy_s[k]  = 1'b1;
        opd_data_s[k] = opd_q_r[k];
      end else begin
        opd_rdy_s[k]  = live_rdy_s[k];
        opd_data_s[k] = live_data_s[k];
      end
      if (!id_valid_r) begin
        opd_data_s[k] = {DATA_W{1'b0}};
      end else begin
        opd_data_s[k] = opd_data_s[k];
      end
    end
  end

  assign stallreq_s = id_valid_r &
                      ((src1_used & ~opd_rdy_s[0]) | (src2_used & ~opd_rdy_s[1]));

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stallreq_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign id_valid  = id_valid_r;
  assign id_pc     = id_pc_r;
  assign id_inst   = id_inst_s;
  assign src1_data = opd_data_s[0];
  assign src2_data = opd_data_s[1];
  assign stallreq  = stallreq_s;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_operand_stage
//
// Directed bench for id_operand_stage. Two instances share all inputs: one
// with default parameters and one with a 4-bit stall counter for the
// saturation case. Inputs change 1 time unit after a rising edge and outputs
// are sampled a further time unit later.
// -----------------------------------------------------------------------------
module tb_id_operand_stage;

  logic        clk;
  logic        rst;
  logic        stall_id;
  logic        stall_ex;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] inst_sram_rdata;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [2:0]  fwd_we;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic [2:0]  fwd_pending;
  logic        src1_used;
  logic        src2_used;

  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] src1_data;
  logic [31:0] src2_data;
  logic        stallreq;
  logic [15:0] stall_cnt;

  logic [4:0]  c4_rf_raddr1;
  logic [4:0]  c4_rf_raddr2;
  logic        c4_id_valid;
  logic [31:0] c4_id_pc;
  logic [31:0] c4_id_inst;
  logic [31:0] c4_src1_data;
  logic [31:0] c4_src2_data;
  logic        c4_stallreq;
  logic [3:0]  c4_stall_cnt;

  int n_tests;
  int n_fail;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex),
    .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_pending(fwd_pending), .src1_used(src1_used), .src2_used(src2_used),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .src1_data(src1_data),
    .src2_data(src2_data), .stallreq(stallreq), .stall_cnt(stall_cnt)
  );

  id_operand_stage #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex),
    .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_pending(fwd_pending), .src1_used(src1_used), .src2_used(src2_used),
    .rf_raddr1(c4_rf_raddr1), .rf_raddr2(c4_rf_raddr2), .id_valid(c4_id_valid),
    .id_pc(c4_id_pc), .id_inst(c4_id_inst), .src1_data(c4_src1_data),
    .src2_data(c4_src2_data), .stallreq(c4_stallreq), .stall_cnt(c4_stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_fwd(input int i, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic p);
    fwd_we[i]             = we;
    fwd_waddr[i*5 +: 5]   = a;
    fwd_wdata[i*32 +: 32] = d;
    fwd_pending[i]        = p;
  endtask

  task automatic clr_fwd();
    fwd_we      = 3'b000;
    fwd_waddr   = 15'h0000;
    fwd_wdata   = 96'h0;
    fwd_pending = 3'b000;
  endtask

  // addu rd, rs, rt
  function automatic logic [31:0] enc(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'b00000, 6'h21};
  endfunction

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    if_valid = 1'b1;
    if_pc = 32'h0000_0F00;
    inst_sram_rdata = 32'h1234_5678;
    rf_rdata1 = 32'h0000_1111;
    rf_rdata2 = 32'h0000_2222;
    src1_used = 1'b1;
    src2_used = 1'b1;
    clr_fwd();

    // ---- reset state (before and across an edge while held) ----
    #2;
    check("rst_valid", {63'd0, id_valid}, 64'd0);
    check("rst_pc", {32'd0, id_pc}, 64'd0);
    check("rst_inst", {32'd0, id_inst}, 64'd0);
    check("rst_src1", {32'd0, src1_data}, 64'd0);
    check("rst_stallreq", {63'd0, stallreq}, 64'd0);
    check("rst_cnt", {48'd0, stall_cnt}, 64'd0);
    check("rst_c4_all", {c4_rf_raddr1, c4_rf_raddr2, c4_id_valid, c4_stallreq,
                         c4_stall_cnt, 40'd0},
          64'd0);
    check("rst_c4_data", {c4_src1_data ^ c4_src2_data, c4_id_pc ^ c4_id_inst}, 64'd0);
    tick();
    check("rst_hold_valid", {63'd0, id_valid}, 64'd0);
    rst = 1'b1;

    // ---- load slot ----
    if_pc = 32'h0000_1000;
    tick();
    check("load_valid", {63'd0, id_valid}, 64'd1);
    check("load_pc", {32'd0, id_pc}, 64'h1000);

    // ---- priority: EX and MEM both write r5 ----
    inst_sram_rdata = enc(5'd5, 5'd0, 5'd6);
    set_fwd(0, 1'b1, 5'd5, 32'h0000_AAAA, 1'b0);
    set_fwd(1, 1'b1, 5'd5, 32'h0000_BBBB, 1'b0);
    settle();
    check("prio_src1", {32'd0, src1_data}, 64'hAAAA);
    check("prio_src2_r0", {32'd0, src2_data}, 64'h0);
    check("prio_stallreq", {63'd0, stallreq}, 64'd0);
    check("prio_raddr1", {59'd0, rf_raddr1}, 64'd5);
    check("prio_inst", {32'd0, id_inst}, {32'd0, enc(5'd5, 5'd0, 5'd6)});
    // pending youngest match blocks even though MEM has r5 ready
    set_fwd(0, 1'b1, 5'd5, 32'h0000_AAAA, 1'b1);
    settle();
    check("prio_pend_block", {63'd0, stallreq}, 64'd1);
    set_fwd(0, 1'b0, 5'd0, 32'h0, 1'b0);
    settle();
    check("prio_mem_src1", {32'd0, src1_data}, 64'hBBBB);
    check("prio_mem_stallreq", {63'd0, stallreq}, 64'd0);
    // rs misses every source, rt hits MEM
    inst_sram_rdata = enc(5'd9, 5'd5, 5'd6);
    settle();
    check("nomatch_src1_rf", {32'd0, src1_data}, 64'h1111);
    check("match_src2_mem", {32'd0, src2_data}, 64'hBBBB);
    clr_fwd();
    settle();
    check("nomatch_src2_rf", {32'd0, src2_data}, 64'h2222);

    // ---- load-use: lw r3 in EX, addu r4,r3,r3 in ID ----
    if_pc = 32'h0000_1004;
    tick();
    check("lu_pc", {32'd0, id_pc}, 64'h1004);
    inst_sram_rdata = enc(5'd3, 5'd3, 5'd4);
    set_fwd(0, 1'b1, 5'd3, 32'h0000_DEAD, 1'b1);
    stall_id = 1'b1;
    stall_ex = 1'b1;
    settle();
    check("lu_stallreq", {63'd0, stallreq}, 64'd1);
    tick();
    // load moved to MEM with data; SRAM output no longer the same word
    clr_fwd();
    set_fwd(1, 1'b1, 5'd3, 32'h0000_1234, 1'b0);
    inst_sram_rdata = 32'hFFFF_FFFF;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    settle();
    check("lu_stallreq_clr", {63'd0, stallreq}, 64'd0);
    check("lu_src1", {32'd0, src1_data}, 64'h1234);
    check("lu_src2", {32'd0, src2_data}, 64'h1234);
    check("lu_inst_held", {32'd0, id_inst}, {32'd0, enc(5'd3, 5'd3, 5'd4)});
    check("lu_cnt", {48'd0, stall_cnt}, 64'd1);
    check("lu_c4_cnt", {60'd0, c4_stall_cnt}, 64'd1);

    // ---- capture: WB forwards r7 only in the first stalled cycle ----
    clr_fwd();
    if_pc = 32'h0000_1008;
    tick();
    inst_sram_rdata = enc(5'd0, 5'd7, 5'd8);
    rf_rdata2 = 32'h0000_0099;
    set_fwd(2, 1'b1, 5'd7, 32'h0000_0055, 1'b0);
    stall_id = 1'b1;
    stall_ex = 1'b1;
    settle();
    check("cap_c1_src2", {32'd0, src2_data}, 64'h55);
    check("cap_c1_stallreq", {63'd0, stallreq}, 64'd0);
    tick();
    clr_fwd();
    inst_sram_rdata = 32'h0000_0000;
    settle();
    check("cap_c2_src2", {32'd0, src2_data}, 64'h55);
    check("cap_c2_inst", {32'd0, id_inst}, {32'd0, enc(5'd0, 5'd7, 5'd8)});
    tick();
    set_fwd(0, 1'b1, 5'd7, 32'h0000_0077, 1'b1);
    settle();
    check("cap_c3_src2", {32'd0, src2_data}, 64'h55);
    check("cap_c3_stallreq", {63'd0, stallreq}, 64'd0);
    check("cap_pre_rst_cnt", {48'd0, stall_cnt}, 64'd1);

    // ---- reset mid-stall with operands captured ----
    rst = 1'b0;
    settle();
    check("midrst_valid", {63'd0, id_valid}, 64'd0);
    check("midrst_src1", {32'd0, src1_data}, 64'd0);
    check("midrst_src2", {32'd0, src2_data}, 64'd0);
    check("midrst_inst", {32'd0, id_inst}, 64'd0);
    check("midrst_cnt", {48'd0, stall_cnt}, 64'd0);
    check("midrst_c4_cnt", {60'd0, c4_stall_cnt}, 64'd0);
    clr_fwd();
    settle();
    rst = 1'b1;

    // ---- bubble ----
    stall_id = 1'b0;
    stall_ex = 1'b0;
    if_pc = 32'h0000_2000;
    inst_sram_rdata = enc(5'd1, 5'd2, 5'd3);
    rf_rdata1 = 32'h0000_1111;
    tick();
    check("bub_pre_valid", {63'd0, id_valid}, 64'd1);
    check("bub_pre_inst", {32'd0, id_inst}, {32'd0, enc(5'd1, 5'd2, 5'd3)});
    stall_id = 1'b1;
    stall_ex = 1'b0;
    tick();
    check("bub_valid", {63'd0, id_valid}, 64'd0);
    check("bub_pc", {32'd0, id_pc}, 64'd0);
    check("bub_inst", {32'd0, id_inst}, 64'd0);
    check("bub_src1", {32'd0, src1_data}, 64'd0);
    set_fwd(0, 1'b1, 5'd1, 32'h0000_0042, 1'b1);
    settle();
    check("bub_stallreq", {63'd0, stallreq}, 64'd0);
    clr_fwd();

    // ---- x0 read with a source writing r0 ----
    stall_id = 1'b0;
    if_pc = 32'h0000_2004;
    tick();
    inst_sram_rdata = enc(5'd0, 5'd0, 5'd1);
    set_fwd(0, 1'b1, 5'd0, 32'h0000_FFFF, 1'b1);
    settle();
    check("x0_src1", {32'd0, src1_data}, 64'd0);
    check("x0_src2", {32'd0, src2_data}, 64'd0);
    check("x0_stallreq", {63'd0, stallreq}, 64'd0);
    check("x0_valid", {63'd0, id_valid}, 64'd1);

    // ---- saturation: hold a load-use stall for 20 cycles ----
    clr_fwd();
    inst_sram_rdata = enc(5'd3, 5'd0, 5'd1);
    set_fwd(0, 1'b1, 5'd3, 32'h0, 1'b1);
    stall_id = 1'b1;
    stall_ex = 1'b1;
    settle();
    check("sat_stallreq", {63'd0, stallreq}, 64'd1);
    check("sat_start_cnt", {48'd0, stall_cnt}, 64'd0);
    repeat (14) tick();
    check("sat_c4_14", {60'd0, c4_stall_cnt}, 64'd14);
    tick();
    check("sat_c4_15", {60'd0, c4_stall_cnt}, 64'd15);
    check("sat_cnt_15", {48'd0, stall_cnt}, 64'd15);
    repeat (5) tick();
    check("sat_c4_20", {60'd0, c4_stall_cnt}, 64'd15);
    check("sat_cnt_20", {48'd0, stall_cnt}, 64'd20);
    check("sat_c4_stallreq", {63'd0, c4_stallreq}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
